drain_ctrl: RTL and testbench
=============================

# drain_ctrl

Sequencer for the systolic-array drain network. On a compute-done pulse it drives the per-row left/right drain enables that feed the shared `drain_channel` pipes. The schedule is collision-free: all left PEs load together, the pipe shifts out, then all right PEs load. It also registers the channel tops into a tagged, valid-qualified output stream. It sits between the array compute controller and the result write-back logic.

## Interface
- `N_ROWS`, default 4: PE rows, equal to the depth of each drain channel; legal range ≥1.
- `N_CH`, default 4: drain channels, each shared by a left/right PE column pair.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, synchronous, active-high.
- `start_i`  in  1  compute-done pulse; requests one drain.
- `busy_o`  out  1  drain sequence in progress.
- `start_drop_o`  out  1  one-cycle pulse when `start_i` is ignored because the block is busy.
- `drain_en_left_o`  out  N_ROWS  per-row left-PE drain enable, broadcast to all channels.
- `drain_en_right_o`  out  N_ROWS  per-row right-PE drain enable.
- `ch_up_i`  in  N_CH × data_t  top-of-channel outputs (row-0 `ch_up_o`).
- `out_valid_o`  out  1  output word valid.
- `out_data_o`  out  N_CH × data_t  registered channel tops.
- `out_row_o`  out  clog2(N_ROWS)  PE row of the current output word.
- `out_side_o`  out  1  0 = left PE, 1 = right PE.
- `done_o`  out  1  one-cycle pulse with the last output word.
- `pe_clear_o`  out  1  one-cycle pulse, coincident with `done_o`; clears PE accumulators.

## Operation
- FSM states: IDLE, LOAD_L, SHIFT_L, LOAD_R, SHIFT_R. The state register resets to IDLE.
- IDLE: when `start_i` is high, go to LOAD_L.
- LOAD_L: lasts 1 cycle. `drain_en_left_o` is all ones. Next state is SHIFT_L, or LOAD_R when N_ROWS = 1.
- SHIFT_L: lasts N_ROWS−1 cycles. All enables are 0 and the channels pass data upward. Next state is LOAD_R.
- LOAD_R: lasts 1 cycle. `drain_en_right_o` is all ones. Next state is SHIFT_R.
- SHIFT_R: lasts N_ROWS cycles. All enables are 0. Next state is IDLE.
- Enables decode from the state register only. Left and right enables are never asserted in the same cycle. Enables are 0 outside the load states.
- Channel-top valid (internal `top_vld`) is true in SHIFT_L, LOAD_R and SHIFT_R: 2·N_ROWS cycles.
- Tag counter:
  - Width clog2(N_ROWS+1); resets to 0.
  - Increments on each `top_vld` cycle.
  - Wraps to 0 after reaching N_ROWS−1.
  - The side bit toggles on each wrap.
- The output stage registers `top_vld`, `ch_up_i`, the tag row and the side bit into `out_valid_o`, `out_data_o`, `out_row_o` and `out_side_o`.
- `start_i` in any non-IDLE state is ignored. It pulses `start_drop_o` on the next cycle and does not affect the sequence.
- `busy_o` = (state ≠ IDLE).
- `done_o` and `pe_clear_o` are registered: they pulse in the cycle after the last SHIFT_R cycle, together with the final `out_valid_o`.
- There is no backpressure; the consumer must accept one word per valid cycle.
- Reset at any point:
  - Next cycle: IDLE, all outputs 0, counter 0.
  - Partially drained data is discarded and no `done_o` is issued.

## Timing
- Reset values: every output 0, including `out_data_o`.
- Cycle numbering: `start_i` is sampled high at the edge ending cycle 0; LOAD_L occupies cycle 1.
- Channel top carries left row r in cycle 2+r and right row r in cycle N_ROWS+2+r.
- `out_valid_o` is high in cycles 3 … 2·N_ROWS+2, with no gaps:
  - left rows 0…N_ROWS−1, then right rows 0…N_ROWS−1.
- `done_o` and `pe_clear_o` pulse in cycle 2·N_ROWS+2.
- The block is in IDLE in cycle 2·N_ROWS+2, so a `start_i` sampled there gives LOAD_L in cycle 2·N_ROWS+3. Back-to-back drains are supported.
- `busy_o` is high in cycles 1 … 2·N_ROWS+1.

## Structure
- common_pkg gains:
  - `drain_state_e`, the FSM enum;
  - `drain_side_e`, with LEFT = 0 and RIGHT = 1;
  - a `drain_tag_t` struct {row, side}.
- Reuse `data_t` and the existing `FF_RESET` macro.
- Sub-module `drain_out_stage`: the registered capture of `ch_up_i` plus the tag and valid. It is parameterised by N_CH and N_ROWS.

## Test plan
All scenarios use N_ROWS=4, N_CH=2; PE(r, L) holds 0x10+r and PE(r, R) holds 0x20+r, using drain_channel models.
- Single drain:
  - `out_data_o[0]` reads 0x10–0x13, then 0x20–0x23, in cycles 3–10.
  - rows/side tags are 0–3/L, then 0–3/R.
  - `done_o` and `pe_clear_o` pulse in cycle 10.
  - `drain_en_left_o` = 4'hF only in cycle 1; `drain_en_right_o` = 4'hF only in cycle 5.
- `start_i` pulsed in cycle 4: `start_drop_o` pulses in cycle 5; the output sequence is identical to the single-drain case.
- `start_i` held high through cycle 10: the second LOAD_L is in cycle 11, and `out_valid_o` resumes in cycle 13 with row 0/L.
- `rst_i` asserted in cycle 7 (SHIFT_R): from cycle 8, all outputs are 0 and the block is IDLE. No `done_o` is issued. A new start then yields the full 8-word sequence.
- N_ROWS=1 build: LOAD_L in cycle 1, LOAD_R in cycle 2; outputs 0x10/L in cycle 3, 0x20/R in cycle 4; `done_o` in cycle 4.

Source files
------------

// File: rtl/drain_ctrl_pkg.sv
// Shared types for the systolic-array drain sequencer: data word, FSM states and output tag.
package drain_ctrl_pkg;

  localparam int DATA_W    = 16;
  localparam int TAG_ROW_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_L  = 3'd1,
    SHIFT_L = 3'd2,
    LOAD_R  = 3'd3,
    SHIFT_R = 3'd4
  } drain_state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } drain_side_e;

  typedef struct packed {
    logic [TAG_ROW_W-1:0] row;
    drain_side_e          side;
  } drain_tag_t;

endpackage

// File: rtl/drain_out_stage.sv
// Registered capture of the channel tops with their row/side tag, valid and last flag.
module drain_out_stage
  import drain_ctrl_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int N_ROWS = 4,
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_p0,
  input  logic                  last_p0,
  input  data_t [N_CH-1:0]      data_p0,
  input  drain_tag_t            tag_p0,
  output logic                  vld_p1,
  output logic                  last_p1,
  output data_t [N_CH-1:0]      data_p1,
  output logic [ROW_W-1:0]      row_p1,
  output drain_side_e           side_p1
);

  // Tag rows are carried at package width; only the low ROW_W bits are meaningful.
  logic unused_tag_row;
  assign unused_tag_row = ^tag_p0.row;

  // p0 -> p1: words are zeroed when not valid so idle cycles present a clean bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
      row_p1  <= '0;
      side_p1 <= LEFT;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      data_p1 <= vld_p0 ? data_p0 : '0;
      row_p1  <= vld_p0 ? tag_p0.row[ROW_W-1:0] : '0;
      side_p1 <= vld_p0 ? tag_p0.side : LEFT;
    end
  end

endmodule

// File: rtl/drain_ctrl.sv
// Drain sequencer: loads all left PEs, shifts the channels out, then loads all right PEs,
// and tags every channel-top word with its PE row and side.
module drain_ctrl
  import drain_ctrl_pkg::*;
#(
  parameter  int N_ROWS = 4,
  parameter  int N_CH   = 4,
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                start_drop_o,
  output logic [N_ROWS-1:0]   drain_en_left_o,
  output logic [N_ROWS-1:0]   drain_en_right_o,
  input  data_t [N_CH-1:0]    ch_up_i,
  output logic                out_valid_o,
  output data_t [N_CH-1:0]    out_data_o,
  output logic [ROW_W-1:0]    out_row_o,
  output logic                out_side_o,
  output logic                done_o,
  output logic                pe_clear_o
);

  localparam int CNT_W = $clog2(N_ROWS + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N_ROWS - 1);
  localparam logic [CNT_W-1:0] SHL_LAST = CNT_W'((N_ROWS > 1) ? N_ROWS - 2 : 0);

  drain_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  drain_side_e      side_q;
  logic             start_drop_q;
  logic             top_vld;
  logic             last_vld;
  drain_tag_t       tag_p0;
  drain_side_e      side_p1;

  assign top_vld  = (state_q == SHIFT_L) || (state_q == LOAD_R) || (state_q == SHIFT_R);
  assign last_vld = (state_q == SHIFT_R) && (cnt_q == LAST_ROW);

  // The tag counter doubles as the shift-phase timer, so phase lengths follow the row count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD_L;
      LOAD_L:  state_d = (N_ROWS == 1) ? LOAD_R : SHIFT_L;
      SHIFT_L: if (cnt_q == SHL_LAST) state_d = LOAD_R;
      LOAD_R:  state_d = SHIFT_R;
      SHIFT_R: if (cnt_q == LAST_ROW) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      side_q       <= LEFT;
      start_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_drop_q <= start_i && (state_q != IDLE);
      if (top_vld) begin
        if (cnt_q == LAST_ROW) begin
          cnt_q  <= '0;
          side_q <= (side_q == LEFT) ? RIGHT : LEFT;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign tag_p0 = {TAG_ROW_W'(cnt_q), side_q};

  drain_out_stage #(
    .N_CH   (N_CH),
    .N_ROWS (N_ROWS)
  ) u_out_stage (
    .clk     (clk_i),
    .rst     (rst_i),
    .vld_p0  (top_vld),
    .last_p0 (last_vld),
    .data_p0 (ch_up_i),
    .tag_p0  (tag_p0),
    .vld_p1  (out_valid_o),
    .last_p1 (done_o),
    .data_p1 (out_data_o),
    .row_p1  (out_row_o),
    .side_p1 (side_p1)
  );

  assign out_side_o       = side_p1;
  assign pe_clear_o       = done_o;
  assign busy_o           = (state_q != IDLE);
  assign start_drop_o     = start_drop_q;
  assign drain_en_left_o  = {N_ROWS{state_q == LOAD_L}};
  assign drain_en_right_o = {N_ROWS{state_q == LOAD_R}};

endmodule

// File: tb/tb_drain_ctrl.sv
// Directed bench for drain_ctrl: N_ROWS=4/N_CH=2 and N_ROWS=1 builds fed by drain-channel models.
module tb_drain_ctrl;
  import drain_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;

  logic              busy, drop, valid, side, done, clr;
  logic [NR-1:0]     en_l, en_r;
  data_t [NC-1:0]    ch_up, data;
  logic [1:0]        row;

  logic              busy1, drop1, valid1, side1, done1, clr1;
  logic [0:0]        en_l1, en_r1, row1;
  data_t [NC-1:0]    ch_up1, data1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  drain_ctrl #(.N_ROWS(NR), .N_CH(NC)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .start_drop_o(drop),
    .drain_en_left_o(en_l), .drain_en_right_o(en_r), .ch_up_i(ch_up),
    .out_valid_o(valid), .out_data_o(data), .out_row_o(row), .out_side_o(side),
    .done_o(done), .pe_clear_o(clr)
  );

  drain_ctrl #(.N_ROWS(1), .N_CH(NC)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .busy_o(busy1), .start_drop_o(drop1),
    .drain_en_left_o(en_l1), .drain_en_right_o(en_r1), .ch_up_i(ch_up1),
    .out_valid_o(valid1), .out_data_o(data1), .out_row_o(row1), .out_side_o(side1),
    .done_o(done1), .pe_clear_o(clr1)
  );

  function automatic data_t pe_val(input int c, input int r, input bit right_side);
    return data_t'(16'h10 + (right_side ? 16'h10 : 16'h0) + r + 16'h100 * c);
  endfunction

  // Drain-channel models: a load enable captures the PE value, otherwise data moves one row up.
  data_t ch4 [NC][NR];
  data_t chm1 [NC];

  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (en_l[r])      ch4[c][r] <= pe_val(c, r, 1'b0);
        else if (en_r[r]) ch4[c][r] <= pe_val(c, r, 1'b1);
        else if (r == NR - 1) ch4[c][r] <= '0;
        else              ch4[c][r] <= ch4[c][r+1];
      end
      if (en_l1[0])      chm1[c] <= pe_val(c, 0, 1'b0);
      else if (en_r1[0]) chm1[c] <= pe_val(c, 0, 1'b1);
      else               chm1[c] <= '0;
    end
  end

  assign ch_up  = {ch4[1][0], ch4[0][0]};
  assign ch_up1 = {chm1[1], chm1[0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle4(input string tag);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " valid"}, valid, 1'b0);
    chk({tag, " data"}, data, '0);
    chk({tag, " row"}, row, 2'd0);
    chk({tag, " side"}, side, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " clr"}, clr, 1'b0);
    chk({tag, " en_l"}, en_l, 4'h0);
    chk({tag, " en_r"}, en_r, 4'h0);
  endtask

  // Entered in cycle 1 of a drain; checks cycles 1..10 and leaves the bench in cycle 11.
  task automatic drain_seq(input string tag, input int drop_at, input bit hold);
    for (int c = 1; c <= 10; c++) begin
      logic        e_vld;
      logic [15:0] e_d0;
      e_vld = (c >= 3);
      e_d0  = (c < 3) ? 16'h0 : (c <= 6) ? 16'(16'h10 + c - 3) : 16'(16'h20 + c - 7);
      chk($sformatf("%s c%0d en_l", tag, c), en_l, (c == 1) ? 4'hF : 4'h0);
      chk($sformatf("%s c%0d en_r", tag, c), en_r, (c == 5) ? 4'hF : 4'h0);
      chk($sformatf("%s c%0d busy", tag, c), busy, (c <= 9));
      chk($sformatf("%s c%0d valid", tag, c), valid, e_vld);
      chk($sformatf("%s c%0d data0", tag, c), data[0], e_d0);
      chk($sformatf("%s c%0d data1", tag, c), data[1], e_vld ? 16'(e_d0 + 16'h100) : 16'h0);
      chk($sformatf("%s c%0d row", tag, c), row, e_vld ? 2'((c - 3) % 4) : 2'd0);
      chk($sformatf("%s c%0d side", tag, c), side, (c >= 7));
      chk($sformatf("%s c%0d done", tag, c), done, (c == 10));
      chk($sformatf("%s c%0d clr", tag, c), clr, (c == 10));
      chk($sformatf("%s c%0d drop", tag, c), drop, (c == drop_at + 1) || (hold && c >= 2));
      start = (c == drop_at) || hold;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk_idle4("reset");
    chk("reset drop", drop, 1'b0);
    chk("reset1 busy", busy1, 1'b0);
    chk("reset1 valid", valid1, 1'b0);
    chk("reset1 data", data1, '0);
    rst = 1'b0;
    tick();

    start = 1'b1;
    tick();
    drain_seq("single", -1, 1'b0);
    chk_idle4("single c11");

    start = 1'b1;
    tick();
    drain_seq("dropped", 4, 1'b0);
    chk_idle4("dropped c11");

    start = 1'b1;
    tick();
    drain_seq("held", -1, 1'b1);
    drain_seq("b2b", -1, 1'b0);
    chk_idle4("b2b c21");

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    chk("rst c7 busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 8; c <= 11; c++) begin
      chk_idle4($sformatf("rst c%0d", c));
      chk($sformatf("rst c%0d drop", c), drop, 1'b0);
      tick();
    end
    start = 1'b1;
    tick();
    drain_seq("after rst", -1, 1'b0);
    chk_idle4("after rst c11");

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("n1 c1 en_l", en_l1, 1'b1);
    chk("n1 c1 en_r", en_r1, 1'b0);
    chk("n1 c1 busy", busy1, 1'b1);
    tick();
    chk("n1 c2 en_l", en_l1, 1'b0);
    chk("n1 c2 en_r", en_r1, 1'b1);
    chk("n1 c2 valid", valid1, 1'b0);
    tick();
    chk("n1 c3 valid", valid1, 1'b1);
    chk("n1 c3 data0", data1[0], 16'h10);
    chk("n1 c3 data1", data1[1], 16'h110);
    chk("n1 c3 row", row1, 1'b0);
    chk("n1 c3 side", side1, 1'b0);
    chk("n1 c3 done", done1, 1'b0);
    chk("n1 c3 busy", busy1, 1'b1);
    tick();
    chk("n1 c4 valid", valid1, 1'b1);
    chk("n1 c4 data0", data1[0], 16'h20);
    chk("n1 c4 data1", data1[1], 16'h120);
    chk("n1 c4 row", row1, 1'b0);
    chk("n1 c4 side", side1, 1'b1);
    chk("n1 c4 done", done1, 1'b1);
    chk("n1 c4 clr", clr1, 1'b1);
    chk("n1 c4 busy", busy1, 1'b0);
    tick();
    chk("n1 c5 valid", valid1, 1'b0);
    chk("n1 c5 done", done1, 1'b0);
    chk("n1 c5 drop", drop1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
